// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control.
// Holds the opcode constants, the 4-bit state enum (the codes appear on the
// debug state port), the ALU/mux select encodings and the control bundle
// passed from the output decoder to the top level.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RCOMP   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_out_decode.sv
// Combinational control decode for the multi-cycle main control.
// Maps the current state (and the effective memory-ready flag, which only
// affects the FETCH write strobes) to the datapath control bundle.
// Ports:
//   state     - current FSM state
//   mem_ready - effective memory ready (already forced to 1 when waits are off)
//   ctrl      - control outputs; unreachable state codes decode to all zero
module multicycle_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC load only on the cycle the instruction word arrives.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                // Held for the whole access, not just the completing cycle.
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RCOMP: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing the shared ALU/memory
// datapath, with a memory-ready handshake, illegal-opcode trap and a
// retired-instruction counter.
//
// state     | meaning
// ----------+------------------------------------------------
// FETCH     | read instruction at PC, PC+4 (waits for mem_ready)
// DECODE    | register read, branch target into ALUOut
// MEMADR    | lw/sw effective address
// MEMRD     | lw data read (waits for mem_ready)
// MEMWB     | lw write-back, retires
// MEMWR     | sw data write (waits for mem_ready), retires
// EXEC      | R-format ALU operation
// RCOMP     | R-format write-back, retires
// BRANCH    | beq compare / conditional PC load, retires
// JUMP      | j PC load, retires
// ADDI_EX   | addi ALU operation
// ADDI_WB   | addi write-back, retires
// TRAP      | unsupported opcode, one-cycle illegal_op pulse
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   op               - IR[31:26], valid from DECODE onward
//   zero             - ALU zero flag (branch resolution happens in the datapath)
//   mem_ready        - memory access completes this cycle
//   pc_write .. pc_source - datapath controls
//   illegal_op       - one-cycle pulse on an unsupported opcode
//   state            - current state code for debug
//   instr_count      - retired instructions, wraps
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EN_JUMP     = 1'b1,
    parameter bit EN_ADDI     = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic             rdy;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl;

    // The zero flag is consumed by the datapath PC-write logic, not here.
    logic zero_unused;
    assign zero_unused = zero;

    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (EN_JUMP && op == OP_J) begin
                    state_d = S_JUMP;
                end else if (EN_ADDI && op == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = rdy ? S_FETCH : S_MEMWR;
                retire  = rdy;
            end
            S_EXEC:    state_d = S_RCOMP;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEMWB, S_RCOMP, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    multicycle_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (rdy),
        .ctrl      (ctrl)
    );

    // Write strobes are masked by reset itself so nothing fires while it is
    // held, even though FETCH would otherwise follow mem_ready.
    assign pc_write      = ctrl.pc_write   & rst_n;
    assign ir_write      = ctrl.ir_write   & rst_n;
    assign reg_write     = ctrl.reg_write  & rst_n;
    assign mem_write     = ctrl.mem_write  & rst_n;
    assign illegal_op    = ctrl.illegal_op & rst_n;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences the shared-ALU/shared-memory MIPS datapath over 3–5 cycles per instruction.
- Supports R-format, lw, sw, beq, and optionally j and addi.
- Adds a variable-latency memory handshake (mem_ready), an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register opcode field and the datapath mux/enable controls; the ALU control block consumes alu_op.

Parameters:
- MEM_WAIT_EN, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1).
- EN_JUMP, 1, 1: decode j (000010); 0: j is illegal.
- EN_ADDI, 1, 1: decode addi (001000); 0: addi is illegal.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode, IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag, for beq.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state code, for debug.
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12. Codes 13–15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Reset: state = FETCH, instr_count = 0.
  - While rst_n = 0, pc_write, ir_write, reg_write, mem_write and illegal_op are forced to 0.
  - All other outputs show their FETCH values.
- Outputs are decoded from state only, except the write strobes gated by mem_ready (noted below). Any output not listed for a state is 0.
- FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00; ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state by op: lw or sw -> MEMADR; R-format -> EXEC; beq -> BRANCH; j -> JUMP (if EN_JUMP); addi -> ADDI_EX (if EN_ADDI); otherwise TRAP.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read = 1, i_or_d = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retires; next FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Waits for mem_ready; mem_write stays high until completion. Retires on the mem_ready cycle; next FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next RCOMP.
- RCOMP: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retires; next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Retires whether or not the branch is taken; next FETCH.
- JUMP: pc_write = 1, pc_source = 10. Retires; next FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retires; next FETCH.
- TRAP: illegal_op = 1 for one cycle; no write strobes; does not retire; next FETCH. The PC was already advanced, so the instruction acts as a no-op.
- Cycle counts with zero wait states: lw 5; sw, R-format, addi 4; beq, j 3; illegal 3. Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- instr_count increments by 1 on the clock edge leaving a retiring state, and wraps modulo 2^CNT_W.
- With MEM_WAIT_EN = 0, mem_ready is ignored and every memory state takes exactly one cycle.
- Reset asserted mid-instruction: state returns to FETCH and instr_count clears immediately; no partial write strobe survives.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010, OP_ADDI 001000;
  - the state enum (4-bit, codes above);
  - the alu_op, alu_src_b and pc_source encodings.
- One natural sub-module: multicycle_out_decode, a purely combinational map from state and mem_ready to the control outputs. The FSM and counter stay in the top module.

Test Plan:
- Reset with op = 100011, mem_ready = 1, then release -> states 0,1,2,3,4; reg_write = 1 and mem_to_reg = 1 in state 4; instr_count = 1 after 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write high for 4 cycles, i_or_d = 1 throughout, no reg_write; instr_count increments only on completion.
- R-format then beq -> 4 + 3 cycles; alu_op 10 in EXEC and 01 in BRANCH; pc_write_cond = 1 and pc_source = 01 in state 8; instr_count = 2.
- op = 111111 -> states 0,1,12; illegal_op high exactly 1 cycle; instr_count unchanged. Repeat with EN_JUMP = 0 and op = 000010 -> same trap response.
- FETCH with mem_ready = 0 for 5 cycles -> state stays 0; ir_write and pc_write stay 0 until the ready cycle, then pulse for one cycle.
- CNT_W = 4: retire 16 addi instructions -> instr_count wraps to 0. Assert rst_n low in MEMRD -> state 0 and count 0 immediately; write strobes stay 0 while reset is held.
